// File: rtl/varredor_matriz_pisca_if.sv
// Matrix-driver bus: scan enable, steady/blink column maps, flash request,
// and the registered row/column drive coming back from the driver.
interface varredor_matriz_pisca_if;
  logic       enable;
  logic [6:0] mapa0;
  logic [6:0] mapa1;
  logic [6:0] mapa2;
  logic [6:0] mapa3;
  logic [6:0] mapa4;
  logic [6:0] pisca0;
  logic [6:0] pisca1;
  logic [6:0] pisca2;
  logic [6:0] pisca3;
  logic [6:0] pisca4;
  logic       flash_all;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic [2:0] coluna_atual;
  logic       fase;

  modport master (
    output enable, mapa0, mapa1, mapa2, mapa3, mapa4,
           pisca0, pisca1, pisca2, pisca3, pisca4, flash_all,
    input  linhas, colunas, coluna_atual, fase
  );

  modport slave (
    input  enable, mapa0, mapa1, mapa2, mapa3, mapa4,
           pisca0, pisca1, pisca2, pisca3, pisca4, flash_all,
    output linhas, colunas, coluna_atual, fase
  );
endinterface

// File: rtl/varredor_matriz_pisca.sv
// Time-multiplexed 7x5 LED matrix driver with a steady plane, a blink plane
// and a whole-matrix flash; one blank clock precedes every lit column.
module varredor_matriz_pisca #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLINK_CYCLES = 381
) (
  input logic                     clock,
  input logic                     reset,
  varredor_matriz_pisca_if.slave  bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BCNT_W = 16;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ROWS   = 7;
  localparam int unsigned COLS   = 5;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_CYCLES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [COLS-1:0]   COLS_OFF  = '1;

  // Scan and blink state
  logic [CNT_W-1:0]  cnt,  cnt_nx;
  logic [COL_W-1:0]  col,  col_nx;
  logic [BCNT_W-1:0] bcnt, bcnt_nx;
  logic              fase, fase_nx;

  // Registered matrix drive
  logic [ROWS-1:0]   linhas,       linhas_nx;
  logic [COLS-1:0]   colunas,      colunas_nx;
  logic [COL_W-1:0]  coluna_atual, coluna_atual_nx;

  // Column slice of both planes for the column currently being scanned
  logic [ROWS-1:0]   mapa_sel_c;
  logic [ROWS-1:0]   pisca_sel_c;
  logic [ROWS-1:0]   pixels_c;

  always_comb begin
    mapa_sel_c  = '0;
    pisca_sel_c = '0;
    case (col)
      3'd0: begin mapa_sel_c = bus.mapa0; pisca_sel_c = bus.pisca0; end
      3'd1: begin mapa_sel_c = bus.mapa1; pisca_sel_c = bus.pisca1; end
      3'd2: begin mapa_sel_c = bus.mapa2; pisca_sel_c = bus.pisca2; end
      3'd3: begin mapa_sel_c = bus.mapa3; pisca_sel_c = bus.pisca3; end
      3'd4: begin mapa_sel_c = bus.mapa4; pisca_sel_c = bus.pisca4; end
      default: begin mapa_sel_c = '0; pisca_sel_c = '0; end
    endcase
  end

  // Flash gates the union of both planes; otherwise only the blink plane is gated
  always_comb begin
    pixels_c = '0;
    if (bus.flash_all) begin
      pixels_c = (mapa_sel_c | pisca_sel_c) & {ROWS{fase}};
    end else begin
      pixels_c = mapa_sel_c | (pisca_sel_c & {ROWS{fase}});
    end
  end

  // Next-state and next-output logic; disabled scan behaves exactly like reset
  always_comb begin
    cnt_nx          = '0;
    col_nx          = '0;
    bcnt_nx         = '0;
    fase_nx         = 1'b0;
    linhas_nx       = '0;
    colunas_nx      = COLS_OFF;
    coluna_atual_nx = '0;

    if (bus.enable) begin
      if (cnt == CNT_LAST) begin
        cnt_nx = '0;
        col_nx = (col == COL_LAST) ? '0 : col + COL_W'(1);
      end else begin
        cnt_nx = cnt + CNT_W'(1);
        col_nx = col;
      end

      if (bcnt == BCNT_LAST) begin
        bcnt_nx = '0;
        fase_nx = ~fase;
      end else begin
        bcnt_nx = bcnt + BCNT_W'(1);
        fase_nx = fase;
      end

      // Slot 0 of every column is blank so the old column never ghosts into the new one
      if (cnt == '0) begin
        linhas_nx  = '0;
        colunas_nx = COLS_OFF;
      end else begin
        linhas_nx  = pixels_c;
        colunas_nx = ~(COLS'(1) << col);
      end
      coluna_atual_nx = col;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      col          <= '0;
      bcnt         <= '0;
      fase         <= 1'b0;
      linhas       <= '0;
      colunas      <= COLS_OFF;
      coluna_atual <= '0;
    end else begin
      cnt          <= cnt_nx;
      col          <= col_nx;
      bcnt         <= bcnt_nx;
      fase         <= fase_nx;
      linhas       <= linhas_nx;
      colunas      <= colunas_nx;
      coluna_atual <= coluna_atual_nx;
    end
  end

  assign bus.linhas       = linhas;
  assign bus.colunas      = colunas;
  assign bus.coluna_atual = coluna_atual;
  assign bus.fase         = fase;

endmodule
